// File: rtl/fproc_meas_resp.sv
// Measurement responder for the fproc interface: latches per-channel result bits and answers each core's
// immediate or wait-mode request. Optional wait timeout is enabled by defining FPROC_TIMEOUT_EN.
module fproc_meas_resp #(
  parameter int N_CORES        = 4,
  parameter int N_MEAS         = 8,
  parameter int FPROC_ID_WIDTH = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_CORES-1:0]             fproc_enable,
  input  logic [N_CORES*FPROC_ID_WIDTH-1:0] fproc_id,
  output logic [N_CORES-1:0]             fproc_ready,
  output logic [N_CORES*DATA_WIDTH-1:0]  fproc_data,
  input  logic [N_MEAS-1:0]              meas,
  input  logic [N_MEAS-1:0]              meas_valid,
  output logic [N_CORES-1:0]             busy
);

  localparam int IW = FPROC_ID_WIDTH - 1;
  localparam int KW = (N_MEAS > 1) ? $clog2(N_MEAS) : 1;

  // Handshake: fproc_enable[c] is a one-cycle request accepted only in IDLE; fproc_ready[c] is a
  // one-cycle response pulse (the RESP state) with fproc_data[c] valid in that cycle and held afterwards.
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  logic [N_MEAS-1:0] stored_q, stored_d;
  logic [N_MEAS-1:0] seen_q, seen_d;

  function automatic logic [DATA_WIDTH-1:0] resp_word(input logic tmo, input logic seen,
                                                       input logic res);
    logic [DATA_WIDTH-1:0] w;
    w = '0;
    w[DATA_WIDTH-1] = tmo;
    w[1] = seen;
    w[0] = res;
    return w;
  endfunction

  always_comb begin
    stored_d = (stored_q & ~meas_valid) | (meas & meas_valid);
    seen_d   = seen_q | meas_valid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stored_q <= '0;
      seen_q   <= '0;
    end else begin
      stored_q <= stored_d;
      seen_q   <= seen_d;
    end
  end

  for (genvar c = 0; c < N_CORES; c++) begin : g_core
    state_t                state_q, state_d;
    logic [KW-1:0]         chan_q, chan_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [IW-1:0]         req_idx;
    logic [KW-1:0]         req_k;
    logic                  req_wait;
    logic                  req_ok;

    assign req_idx  = fproc_id[c*FPROC_ID_WIDTH +: IW];
    assign req_wait = fproc_id[c*FPROC_ID_WIDTH + IW];
    assign req_k    = req_idx[KW-1:0];
    assign req_ok   = {1'b0, req_idx} < (IW+1)'(N_MEAS);

`ifdef FPROC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
      state_d = state_q;
      chan_d  = chan_q;
      data_d  = data_q;
`ifdef FPROC_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
        IDLE: begin
          if (fproc_enable[c]) begin
            chan_d = req_k;
            if (!req_ok) begin
              state_d = RESP;
              data_d  = '0;
            end else if (!req_wait) begin
              // Same-cycle measurement bypasses the store.
              state_d = RESP;
              data_d  = resp_word(1'b0, seen_q[req_k] | meas_valid[req_k],
                                  meas_valid[req_k] ? meas[req_k] : stored_q[req_k]);
            end else if (meas_valid[req_k]) begin
              state_d = RESP;
              data_d  = resp_word(1'b0, 1'b1, meas[req_k]);
            end else begin
              state_d = WAIT;
`ifdef FPROC_TIMEOUT_EN
              cnt_d   = CW'(1);
`endif
            end
          end
        end
        WAIT: begin
          if (meas_valid[chan_q]) begin
            state_d = RESP;
            data_d  = resp_word(1'b0, 1'b1, meas[chan_q]);
`ifdef FPROC_TIMEOUT_EN
          end else if (cnt_q == CW'(TIMEOUT_CYCLES)) begin
            state_d = RESP;
            data_d  = resp_word(1'b1, seen_q[chan_q], stored_q[chan_q]);
          end else begin
            cnt_d = cnt_q + 1'b1;
`endif
          end
        end
        RESP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= IDLE;
        chan_q  <= '0;
        data_q  <= '0;
`ifdef FPROC_TIMEOUT_EN
        cnt_q   <= '0;
`endif
      end else begin
        state_q <= state_d;
        chan_q  <= chan_d;
        data_q  <= data_d;
`ifdef FPROC_TIMEOUT_EN
        cnt_q   <= cnt_d;
`endif
      end
    end

    assign fproc_ready[c]                    = (state_q == RESP);
    assign busy[c]                           = (state_q != IDLE);
    assign fproc_data[c*DATA_WIDTH +: DATA_WIDTH] = data_q;
  end

endmodule

// File: tb/tb_fproc_meas_resp.sv
// Directed bench for fproc_meas_resp; timeout vectors are compiled when FPROC_TIMEOUT_EN is defined.
module tb_fproc_meas_resp;
  localparam int NC  = 4;
  localparam int NM  = 8;
  localparam int IDW = 8;
  localparam int DW  = 32;
`ifdef FPROC_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [NC-1:0]     fproc_enable;
  logic [NC*IDW-1:0] fproc_id;
  logic [NC-1:0]     fproc_ready;
  logic [NC*DW-1:0]  fproc_data;
  logic [NM-1:0]     meas;
  logic [NM-1:0]     meas_valid;
  logic [NC-1:0]     busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  fproc_meas_resp #(
    .N_CORES(NC), .N_MEAS(NM), .FPROC_ID_WIDTH(IDW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .fproc_enable(fproc_enable), .fproc_id(fproc_id),
    .fproc_ready(fproc_ready), .fproc_data(fproc_data), .meas(meas),
    .meas_valid(meas_valid), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] data_of(input int c);
    return fproc_data[c*DW +: DW];
  endfunction

  task automatic issue(input int c, input logic [IDW-1:0] id, input bit push,
                       input logic [DW-1:0] exp);
    fproc_id[c*IDW +: IDW] = id;
    fproc_enable[c] = 1'b1;
    if (push) exp_q.push_back(exp);
  endtask

  // Scoreboard: every ready pulse must match the next expected response word.
  always @(negedge clk) begin
    if (!reset) begin
      for (int c = 0; c < NC; c++) begin
        if (fproc_ready[c]) begin
          if (exp_q.size() == 0) check_eq("sb_extra_ready", DW'(fproc_ready[c]), '0);
          else check_eq("sb_data", data_of(c), exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; fproc_enable = '0; fproc_id = '0; meas = '0; meas_valid = '0;
    repeat (3) tick();
    check_eq("rst_ready", DW'(fproc_ready), '0);
    check_eq("rst_busy", DW'(busy), '0);
    for (int c = 0; c < NC; c++) check_eq("rst_data", data_of(c), '0);
    reset = 1'b0;
    tick();

    // immediate request, channel never measured
    issue(0, 8'h03, 1, 32'h0); tick(); fproc_enable = '0;
    check_eq("imm0_ready", DW'(fproc_ready[0]), 1);
    check_eq("imm0_data", data_of(0), 32'h0);
    check_eq("imm0_busy", DW'(busy[0]), 1);
    tick();
    check_eq("imm0_ready_drop", DW'(fproc_ready[0]), 0);
    check_eq("imm0_idle", DW'(busy[0]), 0);

    // stored result, then same-cycle bypass
    meas[3] = 1'b1; meas_valid[3] = 1'b1; tick(); meas = '0; meas_valid = '0;
    repeat (4) tick();
    issue(1, 8'h03, 1, 32'h3); tick(); fproc_enable = '0;
    check_eq("imm_stored_ready", DW'(fproc_ready[1]), 1);
    check_eq("imm_stored_data", data_of(1), 32'h3);
    tick();
    meas[3] = 1'b0; meas_valid[3] = 1'b1; issue(1, 8'h03, 1, 32'h2); tick();
    meas_valid = '0; fproc_enable = '0;
    check_eq("imm_bypass_data", data_of(1), 32'h2);
    tick();
    issue(1, 8'h03, 1, 32'h2); tick(); fproc_enable = '0;
    check_eq("imm_after_bypass", data_of(1), 32'h2);
    tick();

    // two cores waiting on one channel
    issue(0, 8'h85, 1, 32'h3); issue(2, 8'h85, 1, 32'h3); tick(); fproc_enable = '0;
    repeat (29) tick();
    check_eq("wait_busy", DW'(busy), 32'h5);
    check_eq("wait_no_ready", DW'(fproc_ready), '0);
    meas[5] = 1'b1; meas_valid[5] = 1'b1; tick(); meas = '0; meas_valid = '0;
    check_eq("wait_ready", DW'(fproc_ready), 32'h5);
    check_eq("wait_data0", data_of(0), 32'h3);
    check_eq("wait_data2", data_of(2), 32'h3);
    tick();
    check_eq("wait_busy_low", DW'(busy), '0);

    // invalid channel, enable during RESP ignored
    issue(1, 8'h0F, 1, 32'h0); tick();
    check_eq("inv_ready", DW'(fproc_ready[1]), 1);
    check_eq("inv_data", data_of(1), 32'h0);
    fproc_id[1*IDW +: IDW] = 8'h03; tick(); fproc_enable = '0;
    check_eq("inv_no_second", DW'(fproc_ready[1]), 0);
    check_eq("inv_idle", DW'(busy[1]), 0);
    issue(2, 8'h8F, 1, 32'h0); tick(); fproc_enable = '0;
    check_eq("inv_wait_data", data_of(2), 32'h0);
    tick();

    // wait mode with measurement in the request cycle
    meas[2] = 1'b1; meas_valid[2] = 1'b1; issue(2, 8'h82, 1, 32'h3); tick();
    meas = '0; meas_valid = '0; fproc_enable = '0;
    check_eq("wait_now_ready", DW'(fproc_ready[2]), 1);
    check_eq("wait_now_data", data_of(2), 32'h3);
    tick();

`ifdef FPROC_TIMEOUT_EN
    issue(0, 8'h81, 1, 32'h8000_0000); tick(); fproc_enable = '0;
    repeat (15) tick();
    check_eq("to_not_yet", DW'(fproc_ready[0]), 0);
    tick();
    check_eq("to_ready", DW'(fproc_ready[0]), 1);
    check_eq("to_data", data_of(0), 32'h8000_0000);
    tick();
    issue(0, 8'h81, 1, 32'h3); tick(); fproc_enable = '0;
    repeat (15) tick();
    meas[1] = 1'b1; meas_valid[1] = 1'b1; tick(); meas = '0; meas_valid = '0;
    check_eq("to_tie_data", data_of(0), 32'h3);
    tick();
    issue(0, 8'h81, 1, 32'h8000_0003); tick(); fproc_enable = '0;
    repeat (16) tick();
    check_eq("to_seen_data", data_of(0), 32'h8000_0003);
    tick();
`else
    issue(0, 8'h81, 0, 32'h0); tick(); fproc_enable = '0;
    repeat (40) tick();
    check_eq("wait_forever_busy", DW'(busy[0]), 1);
    exp_q.push_back(32'h3);
    meas[1] = 1'b1; meas_valid[1] = 1'b1; tick(); meas = '0; meas_valid = '0;
    check_eq("wait_late_data", data_of(0), 32'h3);
    tick();
`endif

    // reset while core3 waits
    issue(3, 8'h86, 0, 32'h0); tick(); fproc_enable = '0; tick();
    check_eq("rw_busy", DW'(busy[3]), 1);
    reset = 1'b1; #1;
    check_eq("rw_busy_clr", DW'(busy), '0);
    check_eq("rw_data_clr", data_of(2), 32'h0);
    tick(); reset = 1'b0; tick();
    meas[6] = 1'b1; meas_valid[6] = 1'b1; tick(); meas = '0; meas_valid = '0;
    check_eq("rw_no_ready", DW'(fproc_ready), '0);
    tick();
    check_eq("rw_no_ready2", DW'(fproc_ready), '0);
    issue(0, 8'h05, 1, 32'h0); tick(); fproc_enable = '0;
    check_eq("rw_store_clr", data_of(0), 32'h0);
    tick();
    issue(3, 8'h06, 1, 32'h3); tick(); fproc_enable = '0;
    check_eq("rw_new_ready", DW'(fproc_ready[3]), 1);
    check_eq("rw_new_data", data_of(3), 32'h3);
    tick(); tick();

    check_eq("sb_empty", DW'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fproc_meas_resp.md
# fproc_meas_resp

Function-processor responder that terminates the `fproc_iface` requests issued by one or more processor cores. It latches single-bit measurement results from the readout channels. Each core request either returns a channel's latest stored result or blocks until that channel's next measurement arrives. One independent responder FSM runs per core, and all FSMs share the measurement store.

## Interface
Parameters:
- `N_CORES`, 4: number of requesting cores (one fproc channel each)
- `N_MEAS`, 8: number of measurement channels
- `FPROC_ID_WIDTH`, 8: request id width
- `DATA_WIDTH`, 32: response data width
- `TIMEOUT_CYCLES`, 1024: wait-mode timeout; used only with `FPROC_TIMEOUT_EN`

Ports:
- `clk` in 1: single clock domain
- `reset` in 1: asynchronous, active-high; clears all state
- `fproc_enable` in N_CORES: per-core request strobe, one-cycle pulse
- `fproc_id` in N_CORES*FPROC_ID_WIDTH: per-core request id; core c uses slice [c*FPROC_ID_WIDTH +: FPROC_ID_WIDTH]
- `fproc_ready` out N_CORES: per-core response strobe, one-cycle pulse
- `fproc_data` out N_CORES*DATA_WIDTH: per-core response word; core c uses slice [c*DATA_WIDTH +: DATA_WIDTH]
- `meas` in N_MEAS: measurement result bits
- `meas_valid` in N_MEAS: per-channel strobe; `meas[k]` is valid when `meas_valid[k]` is high
- `busy` out N_CORES: core FSM not in IDLE

## Operation
- Store per channel k:
  - `stored[k]` is loaded from `meas[k]` on `meas_valid[k]`.
  - `seen[k]` is set on the first `meas_valid[k]` after reset.
- Id decode, using the low bits of `fproc_id` as the channel index:
  - Channel = `id[FPROC_ID_WIDTH-2:0]`.
  - `id[FPROC_ID_WIDTH-1]` = 0 selects immediate mode; 1 selects wait mode.
- Response word:
  - bit0 = result bit
  - bit1 = `seen[k]`, i.e. channel measured since reset
  - bit31 = timeout flag
  - all other bits 0
- Per-core FSM states: IDLE, WAIT, RESP.
  - IDLE with `fproc_enable[c]` and a channel index ≥ N_MEAS: go to RESP with data = 0.
  - IDLE with `fproc_enable[c]` in immediate mode: go to RESP.
    - Result bit = `meas[k]` if `meas_valid[k]` is high in the same cycle (bypass), else `stored[k]`.
  - IDLE with `fproc_enable[c]` in wait mode:
    - If `meas_valid[k]` is high in the same cycle, go to RESP with `meas[k]`.
    - Otherwise go to WAIT, and latch the channel index.
  - WAIT: on `meas_valid[k]`, go to RESP with `meas[k]` and bit1 = 1.
  - RESP: `fproc_ready[c]` = 1 for exactly this cycle, then go to IDLE.
- `fproc_enable[c]` is ignored unless the FSM is in IDLE; no request queuing.
- `fproc_data[c]` holds its last response value until the next response; it is not cleared in IDLE.
- Cores are fully independent. Any number of cores may wait on the same channel, and one `meas_valid` releases all of them in the same cycle.
- Simultaneous `meas_valid` on several channels are all captured in the same cycle.

## Timing
- Reset values: `fproc_ready` = 0, `fproc_data` = 0, `busy` = 0, all FSMs in IDLE, `stored` = 0, `seen` = 0.
- Immediate mode:
  - Enable at cycle n → `fproc_ready` high at n+1.
  - Data is valid in the same cycle as `fproc_ready`.
- Wait mode:
  - Measurement at cycle m ≥ n → `fproc_ready` high at m+1.
  - The response carries `meas[k]` as sampled at cycle m.
- Back-to-back requests: the earliest new enable is accepted at n+2, the cycle after RESP.
- Reset asserted mid-WAIT or mid-RESP:
  - State returns immediately to reset values.
  - No `fproc_ready` pulse is emitted.
  - The pending request is dropped.
- Register outputs directly; no combinational path from `meas` or `fproc_enable` to `fproc_ready` or `fproc_data`.

## Configuration
- `FPROC_TIMEOUT_EN` defined:
  - Each core has a wait counter that starts on WAIT entry.
  - If no `meas_valid[k]` has arrived by cycle n+TIMEOUT_CYCLES, the FSM goes to RESP.
    - `fproc_ready` is high at n+TIMEOUT_CYCLES+1.
    - data = bit31 set | `seen[k]`<<1 | `stored[k]`.
  - If `meas_valid[k]` and timeout occur in the same cycle, the measurement wins and bit31 = 0.
- `FPROC_TIMEOUT_EN` undefined:
  - WAIT persists indefinitely.
  - bit31 is always 0.
  - No counter logic is present.

## Test plan
- Reset, then core0 immediate request id=0x03 with no prior measurement → `fproc_ready[0]` at n+1, data = 0x0000_0000.
- Channel 3: `meas`=1 with `meas_valid` at cycle 5; core1 immediate request id=0x03 at cycle 10 → response at cycle 11, data = 0x0000_0003. Repeat the request with the enable in the same cycle as a `meas_valid` carrying 0 → data = 0x0000_0002 (bypass).
- Cores 0 and 2 both issue wait requests id=0x85 at cycle 10; channel 5 delivers `meas`=1 with `meas_valid` at cycle 40 → both `fproc_ready` pulse at cycle 41, both data = 0x0000_0003, `busy` low at 42.
- Invalid id 0x0F with N_MEAS=8 → `fproc_ready` at n+1, data = 0. A second enable during RESP is ignored, giving no extra ready pulse.
- With `FPROC_TIMEOUT_EN` and TIMEOUT_CYCLES=16: wait request id=0x81 at cycle n with no measurement → ready at n+17, data = 0x8000_0000. Measurement arriving at the timeout cycle → bit31 = 0.
- Reset asserted while core3 is in WAIT, then measurement arrives after reset release → no `fproc_ready[3]` pulse; core3 accepts a new request normally.
